// File: rtl/cpu_bus_frontend.sv
// ---------------------------------------------------------------------------
// CpuBusFrontend (module cpu_bus_frontend)
//
// Purpose:
//   Generates a slow, programmable CPU clock from the fast AXI_CLK. It also
//   produces a stretched CPU reset. Once per generated CPU clock period it
//   samples a classic multiplexed address/data CPU bus:
//     - a divider counter runs 0..P-1; cpu_clk is high while cnt < H
//     - new P/H requests are queued and applied only at a period boundary
//     - cpu_reset_out stays high until RESET_HOLD CPU clock rises have
//       occurred after CPU_RESET is released
//     - on every CPU clock rise the bus strobes and AD pins are registered.
//       The address is latched when ALE is high, and read/write cycle
//       starts are flagged on falling nRD/nWR.
//
// Ports:
//   AXI_CLK        in   sole clock, all state changes on its rising edge
//   CPU_RESET      in   synchronous active-high reset
//   cfg_div        in   requested CPU clock period (AXI_CLK cycles)
//   cfg_high       in   requested CPU clock high-phase length
//   cfg_load       in   one-cycle strobe requesting cfg_div/cfg_high
//   a_hi           in   upper address pins (ADDR_W-DATA_W bits)
//   ad_in          in   multiplexed address/data pins
//   nRD, nWR       in   raw active-low read/write strobes
//   IO_nM          in   raw IO/memory select
//   ALE            in   raw address latch enable
//   cpu_clk        out  generated CPU clock
//   cpu_clk_rise   out  one-cycle pulse in the cycle cnt = 0
//   cpu_clk_fall   out  one-cycle pulse in the cycle cnt = H
//   cpu_reset_out  out  stretched CPU reset
//   r_A            out  latched full address {a_hi, ad_in}
//   r_AD           out  sampled AD pins
//   r_nRD, r_nWR   out  sampled strobes
//   r_IO_nM        out  sampled IO/memory select
//   rd_start       out  one-cycle pulse when a read cycle begins
//   wr_start       out  one-cycle pulse when a write cycle begins
// ---------------------------------------------------------------------------
module cpu_bus_frontend #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 5,
  parameter int DEF_DIV    = 15,
  parameter int DEF_HIGH   = 5,
  parameter int RESET_HOLD = 255
) (
  input  logic                     AXI_CLK,
  input  logic                     CPU_RESET,
  input  logic [DIV_W-1:0]         cfg_div,
  input  logic [DIV_W-1:0]         cfg_high,
  input  logic                     cfg_load,
  input  logic [ADDR_W-DATA_W-1:0] a_hi,
  input  logic [DATA_W-1:0]        ad_in,
  input  logic                     nRD,
  input  logic                     nWR,
  input  logic                     IO_nM,
  input  logic                     ALE,
  output logic                     cpu_clk,
  output logic                     cpu_clk_rise,
  output logic                     cpu_clk_fall,
  output logic                     cpu_reset_out,
  output logic [ADDR_W-1:0]        r_A,
  output logic [DATA_W-1:0]        r_AD,
  output logic                     r_nRD,
  output logic                     r_nWR,
  output logic                     r_IO_nM,
  output logic                     rd_start,
  output logic                     wr_start
);

  // Hold counter gets one spare code so RESET_HOLD = 0 still has a legal width.
  localparam int HOLD_W = $clog2(RESET_HOLD + 2);

  localparam logic [DIV_W-1:0]  DEF_P    = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0]  DEF_H    = DIV_W'(DEF_HIGH);
  localparam logic [DIV_W-1:0]  MIN_P    = DIV_W'(2);
  localparam logic [DIV_W-1:0]  ONE      = DIV_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RESET_HOLD);

  // Active timing, divider counter and queued reload request.
  logic [DIV_W-1:0]  r_P;
  logic [DIV_W-1:0]  r_H;
  logic [DIV_W-1:0]  r_cnt;
  logic              r_pend;
  logic [DIV_W-1:0]  r_pendDiv;
  logic [DIV_W-1:0]  r_pendHigh;
  logic              r_cpuClk;
  logic [HOLD_W-1:0] r_holdCnt;

  logic [DIV_W-1:0]  w_cfgDiv;
  logic [DIV_W-1:0]  w_cfgHigh;
  logic              w_wrap;
  logic              w_applyValid;
  logic [DIV_W-1:0]  w_applyDiv;
  logic [DIV_W-1:0]  w_applyHigh;
  logic [DIV_W-1:0]  w_pNext;
  logic [DIV_W-1:0]  w_hNext;
  logic [DIV_W-1:0]  w_cntNext;
  logic              w_rise;
  logic              w_fall;

  // Clamp the requested timing so the generated clock always has at least
  // one high and one low cycle. The high clamp uses the already-clamped
  // period, so cfg_div = 1 with any cfg_high yields a 1/1 clock.
  always_comb begin
    w_cfgDiv  = (cfg_div < MIN_P) ? MIN_P : cfg_div;
    w_cfgHigh = cfg_high;
    if (cfg_high == '0) begin
      w_cfgHigh = ONE;
    end else if (cfg_high >= w_cfgDiv) begin
      w_cfgHigh = w_cfgDiv - ONE;
    end
  end

  // Next-state of the divider. A reload takes effect exactly when the
  // counter wraps, so the period in progress always completes with its old
  // timing. A cfg_load arriving in the wrap cycle itself is the newest
  // request and is applied directly rather than waiting a whole period.
  always_comb begin
    w_wrap       = (r_cnt == r_P - ONE);
    w_applyValid = cfg_load | r_pend;
    w_applyDiv   = cfg_load ? w_cfgDiv  : r_pendDiv;
    w_applyHigh  = cfg_load ? w_cfgHigh : r_pendHigh;
    w_pNext      = r_P;
    w_hNext      = r_H;
    if (w_wrap && w_applyValid) begin
      w_pNext = w_applyDiv;
      w_hNext = w_applyHigh;
    end
    w_cntNext = w_wrap ? '0 : r_cnt + ONE;
  end

  // Divider timebase. cpu_clk is registered from the next counter/high
  // values so it equals (cnt < H) every cycle without a combinational
  // comparator (and its glitches) driving the CPU clock pin.
  always_ff @(posedge AXI_CLK) begin
    if (CPU_RESET) begin
      r_cnt      <= '0;
      r_P        <= DEF_P;
      r_H        <= DEF_H;
      r_pend     <= 1'b0;
      r_pendDiv  <= DEF_P;
      r_pendHigh <= DEF_H;
      r_cpuClk   <= 1'b1;
    end else begin
      r_cnt    <= w_cntNext;
      r_P      <= w_pNext;
      r_H      <= w_hNext;
      r_cpuClk <= (w_cntNext < w_hNext);
      if (w_wrap) begin
        r_pend <= 1'b0;
      end else if (cfg_load) begin
        // A later request simply replaces an earlier unapplied one.
        r_pend     <= 1'b1;
        r_pendDiv  <= w_cfgDiv;
        r_pendHigh <= w_cfgHigh;
      end
    end
  end

  // Phase pulses are decoded from the counter and masked by reset, so the
  // very first cycle after release already reports a rise.
  always_comb begin
    w_rise = ~CPU_RESET & (r_cnt == '0);
    w_fall = ~CPU_RESET & (r_cnt == r_H);
  end

  assign cpu_clk      = r_cpuClk;
  assign cpu_clk_rise = w_rise;
  assign cpu_clk_fall = w_fall;

  // Reset stretcher: count CPU clock rises after release and saturate, so
  // the CPU sees a clean reset spanning RESET_HOLD of its own clocks.
  always_ff @(posedge AXI_CLK) begin
    if (CPU_RESET) begin
      r_holdCnt <= '0;
    end else if (w_rise && (r_holdCnt < HOLD_MAX)) begin
      r_holdCnt <= r_holdCnt + HOLD_W'(1);
    end
  end

  assign cpu_reset_out = CPU_RESET | (r_holdCnt < HOLD_MAX);

  // Bus sampler: the CPU bus is only meaningful at CPU clock rises, so all
  // sampling happens in the cpu_clk_rise cycle. Start pulses compare the
  // freshly sampled strobe with the previous sample, so they line up with
  // the r_nRD/r_nWR update. They are held off while the CPU is in reset.
  // Read and write are judged independently.
  always_ff @(posedge AXI_CLK) begin
    if (CPU_RESET) begin
      r_nRD    <= 1'b1;
      r_nWR    <= 1'b1;
      r_IO_nM  <= 1'b0;
      r_AD     <= '0;
      r_A      <= '0;
      rd_start <= 1'b0;
      wr_start <= 1'b0;
    end else begin
      rd_start <= 1'b0;
      wr_start <= 1'b0;
      if (w_rise) begin
        r_nRD    <= nRD;
        r_nWR    <= nWR;
        r_IO_nM  <= IO_nM;
        r_AD     <= ad_in;
        rd_start <= ~cpu_reset_out & r_nRD & ~nRD;
        wr_start <= ~cpu_reset_out & r_nWR & ~nWR;
        if (ALE) begin
          r_A <= {a_hi, ad_in};
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_frontend.sv
// ---------------------------------------------------------------------------
// Testbench for cpu_bus_frontend (RESET_HOLD overridden to 4 so the reset
// stretcher releases within a few CPU clocks).
// ---------------------------------------------------------------------------
module tb_cpu_bus_frontend;

  logic        AXI_CLK = 1'b0;
  logic        CPU_RESET;
  logic [4:0]  cfg_div;
  logic [4:0]  cfg_high;
  logic        cfg_load;
  logic [11:0] a_hi;
  logic [7:0]  ad_in;
  logic        nRD, nWR, IO_nM, ALE;
  logic        cpu_clk, cpu_clk_rise, cpu_clk_fall, cpu_reset_out;
  logic [19:0] r_A;
  logic [7:0]  r_AD;
  logic        r_nRD, r_nWR, r_IO_nM, rd_start, wr_start;

  int errCount   = 0;
  int checkCount = 0;

  typedef struct {
    logic        ale;
    logic [11:0] aHi;
    logic [7:0]  ad;
    logic        nRd;
    logic        nWr;
    logic        ioNm;
    logic [19:0] expA;
    logic        expRd;
    logic        expWr;
  } capVec_t;

  typedef struct {
    int div;
    int high;
    int offset;
    int expHigh;
    int expLow;
  } tmVec_t;

  capVec_t capVecs[7];
  tmVec_t  tmVecs[4];

  cpu_bus_frontend #(
    .ADDR_W(20), .DATA_W(8), .DIV_W(5), .DEF_DIV(15), .DEF_HIGH(5), .RESET_HOLD(4)
  ) dut (
    .AXI_CLK(AXI_CLK), .CPU_RESET(CPU_RESET),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_load(cfg_load),
    .a_hi(a_hi), .ad_in(ad_in),
    .nRD(nRD), .nWR(nWR), .IO_nM(IO_nM), .ALE(ALE),
    .cpu_clk(cpu_clk), .cpu_clk_rise(cpu_clk_rise), .cpu_clk_fall(cpu_clk_fall),
    .cpu_reset_out(cpu_reset_out),
    .r_A(r_A), .r_AD(r_AD), .r_nRD(r_nRD), .r_nWR(r_nWR), .r_IO_nM(r_IO_nM),
    .rd_start(rd_start), .wr_start(wr_start)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  // Watchdog so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge AXI_CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance until the current cycle is a cpu_clk_rise cycle.
  task automatic waitRise(input string name);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cpu_clk_rise) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) checkOutput({name, "_rise_timeout"}, 32'(0), 32'(1));
  endtask

  // Starting in a rise cycle, measure one full CPU clock period and check
  // its high length, low length and the position of the fall pulse.
  task automatic checkWave(input string name, input int expHigh, input int expLow);
    int   hi, lo, fallAt;
    logic done;
    hi = 0; lo = 0; fallAt = -1; done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0 && cpu_clk_rise) begin
        done = 1'b1;
        break;
      end
      if (cpu_clk_fall && fallAt < 0) fallAt = k;
      if (cpu_clk) hi++;
      else lo++;
      step();
    end
    checkOutput({name, "_done"}, 32'(done), 32'(1));
    checkOutput({name, "_high"}, 32'(hi), 32'(expHigh));
    checkOutput({name, "_low"},  32'(lo), 32'(expLow));
    checkOutput({name, "_fallAt"}, 32'(fallAt), 32'(expHigh));
  endtask

  // Count cycles from now until the next rise cycle.
  task automatic countToRise(input string name, input int expCycles);
    int n;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      if (cpu_clk_rise) break;
      step();
      n++;
    end
    checkOutput({name, "_remaining"}, 32'(n), 32'(expCycles));
  endtask

  // Drive one capture vector in the current rise cycle.
  task automatic applyStimulus(input capVec_t v);
    ALE   = v.ale;
    a_hi  = v.aHi;
    ad_in = v.ad;
    nRD   = v.nRd;
    nWR   = v.nWr;
    IO_nM = v.ioNm;
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_cpu_clk"},  32'(cpu_clk), 32'(1));
    checkOutput({name, "_phase"},    32'({cpu_clk_rise, cpu_clk_fall}), 32'(0));
    checkOutput({name, "_rst_out"},  32'(cpu_reset_out), 32'(1));
    checkOutput({name, "_strobes"},  32'({r_nRD, r_nWR, r_IO_nM}), 32'(3'b110));
    checkOutput({name, "_r_AD"},     32'(r_AD), 32'(0));
    checkOutput({name, "_r_A"},      32'(r_A), 32'(0));
    checkOutput({name, "_starts"},   32'({rd_start, wr_start}), 32'(0));
  endtask

  initial begin
    CPU_RESET = 1'b1;
    cfg_div = '0; cfg_high = '0; cfg_load = 1'b0;
    a_hi = '0; ad_in = '0;
    nRD = 1'b1; nWR = 1'b1; IO_nM = 1'b0; ALE = 1'b0;

    //                 ale  aHi     ad     nRd   nWr   io    expA        rd    wr
    capVecs[0] = '{1'b1, 12'hFFE, 8'h34, 1'b1, 1'b1, 1'b1, 20'hFFE34, 1'b0, 1'b0};
    capVecs[1] = '{1'b0, 12'h123, 8'h5A, 1'b0, 1'b1, 1'b1, 20'hFFE34, 1'b1, 1'b0};
    capVecs[2] = '{1'b0, 12'h123, 8'h66, 1'b0, 1'b1, 1'b0, 20'hFFE34, 1'b0, 1'b0};
    capVecs[3] = '{1'b1, 12'hABC, 8'h01, 1'b1, 1'b1, 1'b0, 20'hABC01, 1'b0, 1'b0};
    capVecs[4] = '{1'b0, 12'h000, 8'h77, 1'b0, 1'b0, 1'b1, 20'hABC01, 1'b1, 1'b1};
    capVecs[5] = '{1'b1, 12'h001, 8'hC3, 1'b1, 1'b1, 1'b0, 20'h001C3, 1'b0, 1'b0};
    capVecs[6] = '{1'b0, 12'hFFF, 8'h99, 1'b1, 1'b0, 1'b1, 20'h001C3, 1'b0, 1'b1};

    //               div high offset expHigh expLow
    tmVecs[0] = '{8,  3,   6,     3,      5};
    tmVecs[1] = '{1,  0,   0,     1,      1};
    tmVecs[2] = '{6,  9,   0,     5,      1};
    tmVecs[3] = '{15, 5,   4,     5,      10};

    // Reset state.
    repeat (3) step();
    checkResetState("reset");

    // Release: default 5 high / 10 low, stretcher drops after the 4th rise.
    CPU_RESET = 1'b0;
    #1;
    for (int c = 0; c < 60; c++) begin
      logic [3:0] expVec;
      expVec[3] = ((c % 15) < 5);
      expVec[2] = ((c % 15) == 0);
      expVec[1] = ((c % 15) == 5);
      expVec[0] = (((c + 14) / 15) < 4);
      checkOutput($sformatf("default_c%0d_clk_rise_fall_rst", c),
                  32'({cpu_clk, cpu_clk_rise, cpu_clk_fall, cpu_reset_out}), 32'(expVec));
      step();
    end

    // Bus capture vectors, one per CPU clock rise.
    for (int i = 0; i < 7; i++) begin
      waitRise($sformatf("cap%0d", i));
      applyStimulus(capVecs[i]);
      step();
      checkOutput($sformatf("cap%0d_r_A", i), 32'(r_A), 32'(capVecs[i].expA));
      checkOutput($sformatf("cap%0d_r_AD", i), 32'(r_AD), 32'(capVecs[i].ad));
      checkOutput($sformatf("cap%0d_strobes", i), 32'({r_nRD, r_nWR, r_IO_nM}),
                  32'({capVecs[i].nRd, capVecs[i].nWr, capVecs[i].ioNm}));
      checkOutput($sformatf("cap%0d_starts", i), 32'({rd_start, wr_start}),
                  32'({capVecs[i].expRd, capVecs[i].expWr}));
      step();
      checkOutput($sformatf("cap%0d_starts_gone", i), 32'({rd_start, wr_start}), 32'(0));
      // Pin activity away from a rise must not be captured.
      ALE = 1'b1; a_hi = 12'hAAA; ad_in = 8'hFF; nRD = 1'b0; nWR = 1'b0; IO_nM = ~IO_nM;
      repeat (3) step();
      checkOutput($sformatf("cap%0d_hold_A", i), 32'(r_A), 32'(capVecs[i].expA));
      checkOutput($sformatf("cap%0d_hold_AD", i), 32'(r_AD), 32'(capVecs[i].ad));
    end
    ALE = 1'b0; nRD = 1'b1; nWR = 1'b1;

    // Timing reloads and clamping: old period completes, then new timing.
    begin
      int oldP;
      oldP = 15;
      for (int i = 0; i < 4; i++) begin
        waitRise($sformatf("tm%0d", i));
        repeat (tmVecs[i].offset) step();
        cfg_div  = 5'(tmVecs[i].div);
        cfg_high = 5'(tmVecs[i].high);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        countToRise($sformatf("tm%0d_old", i), oldP - tmVecs[i].offset - 1);
        checkWave($sformatf("tm%0d_new", i), tmVecs[i].expHigh, tmVecs[i].expLow);
        checkWave($sformatf("tm%0d_repeat", i), tmVecs[i].expHigh, tmVecs[i].expLow);
        oldP = tmVecs[i].expHigh + tmVecs[i].expLow;
      end
    end

    // A second cfg_load before the wrap replaces the first one.
    waitRise("ovr");
    step();
    cfg_div = 5'd10; cfg_high = 5'd2; cfg_load = 1'b1;
    step();
    cfg_div = 5'd4;  cfg_high = 5'd1;
    step();
    cfg_load = 1'b0;
    countToRise("ovr_old", 12);
    checkWave("ovr_new", 1, 3);

    // Reset in the low phase, on the wrap cycle, with a reload pending.
    step(); step();
    cfg_div = 5'd8; cfg_high = 5'd3; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    nRD = 1'b0; nWR = 1'b0;
    CPU_RESET = 1'b1;
    step();
    checkResetState("midrst");
    step();
    CPU_RESET = 1'b0;
    nRD = 1'b1; nWR = 1'b1;
    #1;
    checkOutput("midrst_first_rise", 32'(cpu_clk_rise), 32'(1));
    checkWave("midrst_p1", 5, 10);
    checkWave("midrst_p2", 5, 10);
    checkOutput("midrst_rst_out_held", 32'(cpu_reset_out), 32'(1));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cpu_bus_frontend.md
CPU_BUS_FRONTEND -- requirements
Module: cpu_bus_frontend

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, meaning captured address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning multiplexed AD bus width (ADDR_W > DATA_W).
REQ-003 SHALL have parameter DIV_W, default 5, meaning width of divider counter and config fields.
REQ-004 SHALL have parameter DEF_DIV, default 15, meaning reset CPU clock period in AXI_CLK cycles.
REQ-005 SHALL have parameter DEF_HIGH, default 5, meaning reset CPU clock high-phase length in AXI_CLK cycles.
REQ-006 SHALL have parameter RESET_HOLD, default 255, meaning CPU clock rises to hold cpu_reset_out after CPU_RESET release.
REQ-007 SHALL have port AXI_CLK  input  1  sole clock; all state changes on its rising edge.
REQ-008 SHALL have port CPU_RESET  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port cfg_div  input  DIV_W  requested period.
REQ-010 SHALL have port cfg_high  input  DIV_W  requested high-phase length.
REQ-011 SHALL have port cfg_load  input  1  one-cycle strobe requesting new cfg_div/cfg_high.
REQ-012 SHALL have port a_hi  input  ADDR_W-DATA_W  upper address pins.
REQ-013 SHALL have port ad_in  input  DATA_W  AD pins.
REQ-014 SHALL have ports nRD, nWR, IO_nM, ALE  input  1 each  raw CPU bus strobes.
REQ-015 SHALL have port cpu_clk  output  1  generated CPU clock.
REQ-016 SHALL have ports cpu_clk_rise, cpu_clk_fall  output  1 each  one-cycle phase pulses.
REQ-017 SHALL have port cpu_reset_out  output  1  stretched CPU reset.
REQ-018 SHALL have ports r_A (ADDR_W), r_AD (DATA_W), r_nRD, r_nWR, r_IO_nM (1 each)  output  sampled bus.
REQ-019 SHALL have ports rd_start, wr_start  output  1 each  one-cycle bus cycle start pulses.

Function
REQ-020 SHALL keep active period P and high length H registers, loaded with DEF_DIV/DEF_HIGH in reset.
REQ-021 SHALL latch cfg_load request (pending flag) and apply it only on the cycle the counter wraps to 0; later cfg_load before apply overwrites the pending values.
REQ-022 SHALL clamp applied values: P = max(cfg_div,2); H = 1 if cfg_high = 0; H = P-1 if cfg_high >= P.
REQ-023 SHALL run counter cnt 0..P-1, incrementing each cycle, wrapping from P-1 to 0; cnt = 0 in reset.
REQ-024 SHALL drive cpu_clk = (cnt < H), high during reset.
REQ-025 SHALL assert cpu_clk_rise when cnt = 0 and CPU_RESET low; cpu_clk_fall when cnt = H and CPU_RESET low.
REQ-026 SHALL, on each cpu_clk_rise cycle, register nRD, nWR, IO_nM, ad_in into r_nRD, r_nWR, r_IO_nM, r_AD (visible next cycle).
REQ-027 SHALL, on cpu_clk_rise with ALE high, load r_A = {a_hi, ad_in}; r_A otherwise holds.
REQ-028 SHALL pulse rd_start for one cycle, coincident with r_nRD update, when sampled nRD = 0 and previous r_nRD = 1; wr_start likewise for nWR.
REQ-029 SHALL suppress rd_start/wr_start while cpu_reset_out is high.
REQ-030 SHALL count cpu_clk_rise pulses after CPU_RESET falls, saturating at RESET_HOLD; cpu_reset_out = 1 while count < RESET_HOLD.
REQ-031 SHALL treat simultaneous nRD and nWR falls as both pulses asserted (no arbitration).

Reset
REQ-032 SHALL, while CPU_RESET high: cnt=0, P/H=defaults, pending cleared, cpu_clk=1, cpu_clk_rise=cpu_clk_fall=0, cpu_reset_out=1, hold count=0, r_nRD=r_nWR=1, r_IO_nM=0, r_AD=0, r_A=0, rd_start=wr_start=0.
REQ-033 SHALL honour CPU_RESET asserted mid-period or mid-bus-cycle identically, discarding pending cfg_load.

Verification
REQ-034 SHALL verify defaults: release reset -> cpu_clk high 5, low 10 cycles repeating; cpu_clk_rise first cycle after release, then every 15.
REQ-035 SHALL verify reload: cfg_div=8, cfg_high=3, cfg_load at cnt=6 -> old period completes (15), next periods 3 high/5 low.
REQ-036 SHALL verify clamping: cfg_div=1, cfg_high=0 -> period 2, high 1; cfg_div=6, cfg_high=9 -> high 5, low 1.
REQ-037 SHALL verify stretcher with RESET_HOLD=4: cpu_reset_out falls the cycle after the 4th cpu_clk_rise post-release.
REQ-038 SHALL verify capture: ALE=1, a_hi=0xFFE, ad_in=0x34 at a rise -> r_A=0xFFE34; next rise nRD=0 -> rd_start one cycle, r_nRD=0.
REQ-039 SHALL verify mid-operation reset: CPU_RESET pulse during low phase with pending cfg_load -> restart with default 5/10 timing, cpu_reset_out re-asserted.
